prim_bus_arbiter: RTL
=====================

PRIM_BUS_ARBITER -- requirements
Module: prim_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of granted cycles without i_s_ack before a forced termination; legal range 2..255.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports i_m0_addr, i_m0_dat, i_m0_bs, i_m0_we, all inputs, widths 16/16/2/1: master 0 (CPU) address, write data, byte select and write enable.
REQ-005 SHALL have ports o_m0_dat, output, 16, and o_m0_ack, output, 1: master 0 read data and acknowledge.
REQ-006 SHALL have ports i_m1_addr, i_m1_dat, i_m1_bs, i_m1_we, o_m1_dat and o_m1_ack, with the same directions and widths as master 0: master 1 (loader/DMA).
REQ-007 SHALL have ports o_s_addr, o_s_dat, o_s_bs and o_s_we, outputs, widths 16/16/2/1: the shared memory request.
REQ-008 SHALL have ports i_s_dat, input, 16, and i_s_ack, input, 1: memory read data and acknowledge.
REQ-009 SHALL have port o_grant, output, 2 bits: one-hot current grant; 00 when idle.
REQ-010 SHALL have port o_bus_err, output, 1 bit: sticky timeout flag.

Function
REQ-011 A master request is defined as its bs != 00; bs, addr, we and dat are held stable until that master's ack.
REQ-012 The state machine SHALL have three states: IDLE, GNT0, GNT1.
REQ-013 In IDLE with exactly one request pending, the next state SHALL be that master's GNT state.
REQ-014 In IDLE with both requests pending, the grant SHALL go to the master not served last (round-robin pointer).
REQ-015 The round-robin pointer SHALL favour m0 after reset and SHALL update on each completed transfer.
REQ-016 In IDLE with no request pending, the arbiter SHALL stay in IDLE.
REQ-017 In GNTx, the o_s_* outputs SHALL combinationally mirror master x's addr/dat/bs/we.
REQ-018 In IDLE, o_s_addr and o_s_dat SHALL be 0 and o_s_bs and o_s_we SHALL be 0.
REQ-019 o_m0_dat and o_m1_dat SHALL both equal i_s_dat.
REQ-020 o_mx_ack SHALL equal i_s_ack only while in GNTx; it SHALL be 0 otherwise.
REQ-021 On i_s_ack in GNTx, the next state SHALL be IDLE; a grant is never switched mid-transfer.
REQ-022 Latency: a request first seen in IDLE at cycle n SHALL reach the slave at n+1; the minimum transfer is 2 cycles, with 1 idle cycle between back-to-back transfers.
REQ-023 A granted master that drops bs to 00 before its ack is illegal; the arbiter SHALL return to IDLE on the next edge without an ack.

Reset
REQ-024 While i_reset is high at a clock edge, the next state SHALL be IDLE, the pointer SHALL select m0, o_bus_err SHALL clear and the timeout counter SHALL clear.
REQ-025 While i_reset is high, o_s_bs and o_s_we SHALL be forced to 0 combinationally, including when reset is asserted mid-transfer; no ack SHALL be delivered.

Configuration
REQ-026 With macro PRIM_ARB_TIMEOUT_EN defined, a counter SHALL increment each GNTx cycle without ack.
REQ-027 With PRIM_ARB_TIMEOUT_EN defined, on the cycle the counter equals TIMEOUT_CYCLES-1 the arbiter SHALL pulse o_mx_ack, drive o_mx_dat to 16'hFFFF, set o_bus_err and go to IDLE.
REQ-028 With PRIM_ARB_TIMEOUT_EN defined, a real i_s_ack in the same cycle as the timeout SHALL take precedence: real data is returned and o_bus_err is not set.
REQ-029 With PRIM_ARB_TIMEOUT_EN undefined, there SHALL be no counter, o_bus_err SHALL be tied 0, and a grant SHALL wait indefinitely.

Structure
REQ-030 Package prim_bus_pkg SHALL hold the state encoding (IDLE/GNT0/GNT1), the BS constants (BS_NONE=00, BS_BYTE=01, BS_WORD=11) and BUS_ERR_DATA=16'hFFFF.
REQ-031 The sub-module prim_bus_watchdog (counter plus compare) SHALL be instantiated only under PRIM_ARB_TIMEOUT_EN.

Verification
REQ-032 Single m0 read: m0 bs=01, addr=0x0010, slave acks 2 cycles later with 0x00AB -> o_m0_ack=1 and o_m0_dat=0x00AB; o_m1_ack stays 0; state returns to IDLE.
REQ-033 Simultaneous requests after reset: m0 and m1 both bs=11 -> m0 granted first, then m1; a second simultaneous pair -> m0 granted again only after m1 was served.
REQ-034 m1 write: addr=0x8000, dat=0x1234, we=1, bs=11 -> o_s_* mirror m1 exactly; m0's request is held off until the ack, and o_grant goes 10 -> 00 -> 01.
REQ-035 Reset mid-transfer: assert i_reset in GNT0 -> o_s_bs=00 in the same cycle, IDLE next, no ack, o_grant=00.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=4): no slave ack -> o_m0_ack pulses at the 4th granted cycle with 0xFFFF and o_bus_err=1 sticky; with the macro off, the grant holds for more than 100 cycles.

Source files
------------

// File: rtl/prim_bus_pkg.sv
// ============================================================================
// Module      : prim_bus_pkg
// Description : Shared encodings for the two-master bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prim_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0]  BS_NONE      = 2'b00;
  localparam logic [1:0]  BS_BYTE      = 2'b01;
  localparam logic [1:0]  BS_WORD      = 2'b11;
  localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/prim_bus_watchdog.sv
// ============================================================================
// Module      : prim_bus_watchdog
// Description : Counts consecutive unacknowledged granted cycles and flags the
//               cycle on which the count reaches TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  output logic o_expired
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // The counter restarts whenever the grant ends, is acked, or expires.
  always_comb begin
    o_expired = i_active && (cnt_q == CNT_LAST);
    cnt_d     = (i_active && !o_expired) ? cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prim_bus_arbiter.sv
// ============================================================================
// Module      : prim_bus_arbiter
// Description : Round-robin arbiter giving two masters access to one memory
//               port. Optional grant timeout enabled by PRIM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_bus_arbiter
  import prim_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  input  logic [1:0]  i_m0_bs,
  input  logic        i_m0_we,
  output logic [15:0] o_m0_dat,
  output logic        o_m0_ack,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  input  logic [1:0]  i_m1_bs,
  input  logic        i_m1_we,
  output logic [15:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic [15:0] o_s_addr,
  output logic [15:0] o_s_dat,
  output logic [1:0]  o_s_bs,
  output logic        o_s_we,
  input  logic [15:0] i_s_dat,
  input  logic        i_s_ack,
  output logic [1:0]  o_grant,
  output logic        o_bus_err
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       rr_q;      // 1: m1 is favoured on the next contested request
  logic       rr_d;

  logic w_req0;
  logic w_req1;
  logic w_granted;
  logic w_gnt_req;
  logic w_timeout;
  logic w_done;

  assign w_req0    = (i_m0_bs != BS_NONE);
  assign w_req1    = (i_m1_bs != BS_NONE);
  assign w_granted = (state_q != IDLE);
  assign w_gnt_req = ((state_q == GNT0) && w_req0) || ((state_q == GNT1) && w_req1);

`ifdef PRIM_ARB_TIMEOUT_EN
  logic w_wd_active;
  logic err_q;
  logic err_d;

  // A real ack in the same cycle keeps the watchdog quiet, so it wins.
  assign w_wd_active = w_granted && w_gnt_req && !i_s_ack;

  prim_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_active  (w_wd_active),
    .o_expired (w_timeout)
  );

  assign err_d = err_q | w_timeout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_bus_err = err_q;
`else
  assign w_timeout = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  assign w_done = w_granted && (i_s_ack || w_timeout);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (w_req0 && w_req1) begin
          state_d = rr_q ? GNT1 : GNT0;
        end else if (w_req0) begin
          state_d = GNT0;
        end else if (w_req1) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (w_done) begin
          state_d = IDLE;
          rr_d    = (state_q == GNT0);
        end else if (!w_gnt_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; reset presents the idle bus immediately, even mid-transfer.
  always_comb begin
    o_s_addr = 16'h0000;
    o_s_dat  = 16'h0000;
    o_s_bs   = BS_NONE;
    o_s_we   = 1'b0;
    o_grant  = 2'b00;
    o_m0_ack = 1'b0;
    o_m1_ack = 1'b0;
    o_m0_dat = i_s_dat;
    o_m1_dat = i_s_dat;
    if (!i_reset) begin
      case (state_q)
        GNT0: begin
          o_s_addr = i_m0_addr;
          o_s_dat  = i_m0_dat;
          o_s_bs   = i_m0_bs;
          o_s_we   = i_m0_we;
          o_grant  = 2'b01;
          o_m0_ack = i_s_ack | w_timeout;
          if (w_timeout) begin
            o_m0_dat = BUS_ERR_DATA;
          end
        end
        GNT1: begin
          o_s_addr = i_m1_addr;
          o_s_dat  = i_m1_dat;
          o_s_bs   = i_m1_bs;
          o_s_we   = i_m1_we;
          o_grant  = 2'b10;
          o_m1_ack = i_s_ack | w_timeout;
          if (w_timeout) begin
            o_m1_dat = BUS_ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
